operand_stage: RTL

//  Decode->execute boundary. Drives regfile read addresses, picks each source operand

---
 rtl/operand_stage_pkg.sv | 48 ++++
 rtl/operand_stage_if.sv | 11 +
 rtl/operand_bypass.sv | 47 ++++
 rtl/operand_stage.sv | 86 ++++++++
 4 files changed

// File: rtl/operand_stage_pkg.sv
// Shared types for the decode->execute operand stage: machine word, register
// address, control field, decode/execute bundles and bypass descriptors.
package operand_stage_pkg;

   typedef logic [63:0] word_t;
   typedef logic [4:0]  creg_addr_t;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       mem_rd;
      logic       mem_wr;
      logic       wb_en;
      logic       branch;
   } ctl_t;

   typedef struct packed {
      word_t      pc;
      creg_addr_t rs1;
      creg_addr_t rs2;
      creg_addr_t rd;
      logic       use_rs1;
      logic       use_rs2;
      word_t      imm;
      ctl_t       ctl;
   } id_bundle_t;

   typedef struct packed {
      word_t      pc;
      word_t      op1;
      word_t      op2;
      creg_addr_t rd;
      word_t      imm;
      ctl_t       ctl;
   } ex_bundle_t;

   typedef struct packed {
      logic       valid;
      logic       is_load;
      creg_addr_t rd;
      word_t      data;
   } fwd_t;

   // x0 is hardwired, so it never matches a producing stage
   function automatic logic fwd_hit(fwd_t f, creg_addr_t s);
      return f.valid && (f.rd == s) && (s != '0);
   endfunction

endpackage

// File: rtl/operand_stage_if.sv
// Valid/ready bundle channel; the bundle type is chosen per instance.
interface operand_stage_if #(parameter type bundle_t = logic);

   logic    valid;
   logic    ready;
   bundle_t bundle;

   modport master (output valid, output bundle, input ready);
   modport slave  (input valid, input bundle, output ready);

endinterface

// File: rtl/operand_bypass.sv
// Per-source operand select (EX > MEM > WB > regfile) and load-use detection.
// Build option: OPERAND_STAGE_FWD_EN enables the bypass network.
module operand_bypass
   import operand_stage_pkg::*;
(
   input  creg_addr_t addr,
   input  logic       use_src,
   input  word_t      rf_data,
   input  fwd_t       ex,
   input  fwd_t       mem,
   input  fwd_t       wb,
   output word_t      data,
   output logic       hazard
);

   logic ex_hit;
   logic mem_hit;
   logic wb_hit;
   logic unused_bits;

   assign ex_hit  = fwd_hit(ex, addr);
   assign mem_hit = fwd_hit(mem, addr);
   assign wb_hit  = fwd_hit(wb, addr);

   assign unused_bits = ^{ex.is_load, mem.is_load, wb.is_load, ex.data, mem.data, wb.data};

`ifdef OPERAND_STAGE_FWD_EN
   always_comb begin
      data = rf_data;
      if (addr == '0)
         data = '0;
      else if (ex_hit)
         data = ex.data;
      else if (mem_hit)
         data = mem.data;
      else if (wb_hit)
         data = wb.data;
   end

   // a load in EX has no data yet; MEM data is already final
   assign hazard = use_src && ex_hit && ex.is_load;
`else
   assign data   = (addr == '0) ? '0 : rf_data;
   assign hazard = use_src && (ex_hit || mem_hit || wb_hit);
`endif

endmodule

// File: rtl/operand_stage.sv
// Decode->execute operand stage: regfile addressing, bypass/hazard resolution
// and the valid/ready register feeding execute. Build option: OPERAND_STAGE_FWD_EN.
module operand_stage
   import operand_stage_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   operand_stage_if.slave        dec,
   output creg_addr_t            rf_ra1,
   output creg_addr_t            rf_ra2,
   input  word_t                 rf_rd1,
   input  word_t                 rf_rd2,
   input  fwd_t                  ex_fwd,
   input  fwd_t                  mem_fwd,
   input  fwd_t                  wb_fwd,
   operand_stage_if.master       exe,
   output logic [31:0]           stall_cnt
);

   id_bundle_t in_b;
   word_t      op1;
   word_t      op2;
   logic       hz1;
   logic       hz2;
   logic       hazard;
   logic       accept;
   logic       held_valid;
   ex_bundle_t held_bundle;

   assign in_b   = dec.bundle;
   assign rf_ra1 = in_b.rs1;
   assign rf_ra2 = in_b.rs2;

   operand_bypass u_src1 (
      .addr    (in_b.rs1),
      .use_src (in_b.use_rs1),
      .rf_data (rf_rd1),
      .ex      (ex_fwd),
      .mem     (mem_fwd),
      .wb      (wb_fwd),
      .data    (op1),
      .hazard  (hz1)
   );

   operand_bypass u_src2 (
      .addr    (in_b.rs2),
      .use_src (in_b.use_rs2),
      .rf_data (rf_rd2),
      .ex      (ex_fwd),
      .mem     (mem_fwd),
      .wb      (wb_fwd),
      .data    (op2),
      .hazard  (hz2)
   );

   assign hazard    = dec.valid && (hz1 || hz2);
   assign dec.ready = !hazard && (!held_valid || exe.ready) && !flush;
   assign accept    = dec.valid && dec.ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         held_valid  <= 1'b0;
         held_bundle <= '0;
      end else if (flush) begin
         held_valid  <= 1'b0;
      end else if (accept) begin
         held_valid  <= 1'b1;
         held_bundle <= '{pc: in_b.pc, op1: op1, op2: op2, rd: in_b.rd,
                          imm: in_b.imm, ctl: in_b.ctl};
      end else if (held_valid && exe.ready) begin
         held_valid  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt <= '0;
      else if (hazard && !flush)
         stall_cnt <= stall_cnt + 32'd1;
   end

   assign exe.valid  = held_valid;
   assign exe.bundle = held_bundle;

endmodule
